regfile_2r1w: RTL and testbench

- Architectural register file for the 16-bit pipelined datapath; sits directly upstream of the ALU in the decode stage.
- Two read ports supply ALU operands a and b; one write port receives writeback results.
- Register 0 is hardwired to zero; all other registers are general purpose.
- Storage is sequential, with synchronous write; reads are combinational from current state.

---
 rtl/regfile_2r1w_if.sv | 29 ++
 rtl/regfile_2r1w.sv | 54 +++++
 tb/tb_regfile_2r1w.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/regfile_2r1w_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_2r1w_if
// Brief    : Read/write port bundle between decode logic and the register file.
// Revision : 1.0 - initial release
// ============================================================================
interface regfile_2r1w_if #(
    parameter int DSIZE = 16,
    parameter int AW    = 4
);
    logic [AW-1:0]    raddr1;
    logic [AW-1:0]    raddr2;
    logic [DSIZE-1:0] rdata1;
    logic [DSIZE-1:0] rdata2;
    logic             wen;
    logic [AW-1:0]    waddr;
    logic [DSIZE-1:0] wdata;

    modport master (
        output raddr1, raddr2, wen, waddr, wdata,
        input  rdata1, rdata2
    );

    modport slave (
        input  raddr1, raddr2, wen, waddr, wdata,
        output rdata1, rdata2
    );
endinterface
`default_nettype wire

// File: rtl/regfile_2r1w.sv
`default_nettype none
// ============================================================================
// Module   : regfile_2r1w
// Brief    : 2-read/1-write register file, r0 hardwired to zero.
//            Optional macro REGFILE_WRITE_BYPASS_EN adds write-to-read bypass.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_2r1w #(
    parameter int DSIZE = 16,
    parameter int NREG  = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    regfile_2r1w_if.slave    rf
);

    logic [DSIZE-1:0] r_mem [NREG];
    logic             w_wr_en;
    logic [DSIZE-1:0] w_rdata1;
    logic [DSIZE-1:0] w_rdata2;

    assign w_wr_en = rf.wen && (rf.waddr != {AW{1'b0}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_mem[rf.waddr] <= rf.wdata;
        end
    end

    // Address 0 is forced to zero on the read side so r0 never depends on storage.
    always_comb begin
        w_rdata1 = (rf.raddr1 == {AW{1'b0}}) ? {DSIZE{1'b0}} : r_mem[rf.raddr1];
        w_rdata2 = (rf.raddr2 == {AW{1'b0}}) ? {DSIZE{1'b0}} : r_mem[rf.raddr2];
`ifdef REGFILE_WRITE_BYPASS_EN
        if (rst_n && w_wr_en && (rf.raddr1 == rf.waddr)) begin
            w_rdata1 = rf.wdata;
        end
        if (rst_n && w_wr_en && (rf.raddr2 == rf.waddr)) begin
            w_rdata2 = rf.wdata;
        end
`else
`endif
    end

    assign rf.rdata1 = w_rdata1;
    assign rf.rdata2 = w_rdata2;

endmodule
`default_nettype wire

// File: tb/tb_regfile_2r1w.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_2r1w
// Brief    : Directed scoreboard bench for regfile_2r1w.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_2r1w;

    typedef struct {
        string       tag;
        int          port;
        logic [15:0] exp;
    } exp_t;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;
    exp_t sb[$];
    logic [15:0] model [16];

    regfile_2r1w_if #(.DSIZE(16), .AW(4)) rf_bus ();

    regfile_2r1w #(.DSIZE(16), .NREG(16), .AW(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rf    (rf_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [3:0] a, input logic [15:0] d);
        rf_bus.wen   = 1'b1;
        rf_bus.waddr = a;
        rf_bus.wdata = d;
        tick();
        rf_bus.wen   = 1'b0;
    endtask

    task automatic expect_rd(input string tag, input int port, input logic [15:0] e);
        exp_t item;
        item.tag  = tag;
        item.port = port;
        item.exp  = e;
        sb.push_back(item);
    endtask

    task automatic check_all();
        exp_t item;
        logic [15:0] obs;
        #1;
        while (sb.size() > 0) begin
            item = sb.pop_front();
            obs  = (item.port == 1) ? rf_bus.rdata1 : rf_bus.rdata2;
            tests++;
            assert (obs === item.exp)
            else begin
                fails++;
                $error("FAIL %s: observed %h expected %h", item.tag, obs, item.exp);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        rf_bus.raddr1 = 4'd0;
        rf_bus.raddr2 = 4'd5;
        rf_bus.wen    = 1'b0;
        rf_bus.waddr  = 4'd0;
        rf_bus.wdata  = 16'h0000;

        // Reset state
        #12;
        expect_rd("reset_rd1", 1, 16'h0000);
        expect_rd("reset_rd2", 2, 16'h0000);
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Asynchronous reset clears contents before the next edge
        write(4'd5, 16'h1234);
        rf_bus.raddr1 = 4'd5;
        expect_rd("pre_reset_r5", 1, 16'h1234);
        check_all();
        rst_n = 1'b0;
        expect_rd("async_reset_r5", 1, 16'h0000);
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Basic write/read and dual read of one register
        write(4'd3, 16'hA5A5);
        write(4'd7, 16'h0F0F);
        rf_bus.raddr1 = 4'd3;
        rf_bus.raddr2 = 4'd7;
        expect_rd("basic_r3", 1, 16'hA5A5);
        expect_rd("basic_r7", 2, 16'h0F0F);
        check_all();
        rf_bus.raddr2 = 4'd3;
        expect_rd("dual_r3_p1", 1, 16'hA5A5);
        expect_rd("dual_r3_p2", 2, 16'hA5A5);
        check_all();

        // r0 hardwired
        write(4'd0, 16'hFFFF);
        rf_bus.raddr1 = 4'd0;
        rf_bus.raddr2 = 4'd0;
        expect_rd("r0_p1", 1, 16'h0000);
        expect_rd("r0_p2", 2, 16'h0000);
        check_all();

        // wen gating
        write(4'd4, 16'h0001);
        rf_bus.wen   = 1'b0;
        rf_bus.waddr = 4'd4;
        rf_bus.wdata = 16'hBEEF;
        tick(); tick(); tick();
        rf_bus.raddr1 = 4'd4;
        expect_rd("wen_gate_r4", 1, 16'h0001);
        check_all();

        // Read-during-write
        write(4'd9, 16'h1111);
        rf_bus.raddr1 = 4'd9;
        rf_bus.raddr2 = 4'd3;
        rf_bus.wen    = 1'b1;
        rf_bus.waddr  = 4'd9;
        rf_bus.wdata  = 16'h2222;
`ifdef REGFILE_WRITE_BYPASS_EN
        expect_rd("rdw_before", 1, 16'h2222);
`else
        expect_rd("rdw_before", 1, 16'h1111);
`endif
        expect_rd("rdw_other_port", 2, 16'hA5A5);
        check_all();
        tick();
        rf_bus.wen = 1'b0;
        expect_rd("rdw_after", 1, 16'h2222);
        check_all();

        // A write aimed at r0 never shows up on a read of r0
        rf_bus.raddr1 = 4'd0;
        rf_bus.wen    = 1'b1;
        rf_bus.waddr  = 4'd0;
        rf_bus.wdata  = 16'h5555;
        expect_rd("r0_during_write", 1, 16'h0000);
        check_all();
        tick();
        rf_bus.wen = 1'b0;

        // Reset held across an edge with a pending write
        rf_bus.wen   = 1'b1;
        rf_bus.waddr = 4'd2;
        rf_bus.wdata = 16'h3333;
        rst_n = 1'b0;
        rf_bus.raddr1 = 4'd2;
        expect_rd("rst_write_held", 1, 16'h0000);
        check_all();
        tick();
        @(negedge clk);
        rf_bus.wen = 1'b0;
        rst_n = 1'b1;
        rf_bus.raddr2 = 4'd3;
        expect_rd("rst_write_r2", 1, 16'h0000);
        expect_rd("rst_clears_r3", 2, 16'h0000);
        check_all();

        // Model-tracked random writes, then full read-back on both ports
        for (int i = 0; i < 16; i++) model[i] = 16'h0000;
        for (int i = 0; i < 24; i++) begin
            logic [3:0]  a;
            logic [15:0] d;
            a = 4'($urandom_range(0, 15));
            d = 16'($urandom);
            write(a, d);
            if (a != 4'd0) model[a] = d;
        end
        for (int i = 0; i < 16; i++) begin
            rf_bus.raddr1 = 4'(i);
            rf_bus.raddr2 = 4'(15 - i);
            expect_rd($sformatf("sweep_p1_r%0d", i), 1, model[i]);
            expect_rd($sformatf("sweep_p2_r%0d", 15 - i), 2, model[15 - i]);
            check_all();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
